led_sweep_ctrl: RTL and testbench

LED_SWEEP_CTRL -- requirements
Module: led_sweep_ctrl

---
 rtl/led_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_led_sweep_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sweep_ctrl.sv
// Forward/backward LED sweep sequencer with timed pauses, loop counting and a sticky timeout fault.
// Every output is registered (one edge from decision to pin); stop aborts any active state on the next edge.
module led_sweep_ctrl #(
    parameter int DIV         = 50000,
    parameter int PAUSE_TICKS = 10,
    parameter int LOOPS       = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       fwd_done,
    input  logic       bwd_done,
    output logic       fwd_en,
    output logic       bwd_en,
    output logic       sel,
    output logic       busy,
    output logic [7:0] sweep_cnt,
    output logic       run_done,
    output logic       fault
);

    localparam int PW = (DIV > 1)         ? $clog2(DIV)         : 1;
    localparam int TW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
    localparam int OW = (TIMEOUT > 1)     ? $clog2(TIMEOUT)     : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FWD     = 3'd1,
        S_PAUSE_F = 3'd2,
        S_BWD     = 3'd3,
        S_PAUSE_B = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [PW-1:0]  r_pre;
    logic [PW-1:0]  w_pre_nxt;
    logic [TW-1:0]  r_tick;
    logic [TW-1:0]  w_tick_nxt;
    logic [OW-1:0]  r_tmo;
    logic [OW-1:0]  w_tmo_nxt;
    logic           r_fwd_en;
    logic           r_bwd_en;
    logic           r_sel;
    logic           w_sel_nxt;
    logic           r_busy;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic           r_run_done;
    logic           w_run_done_nxt;
    logic           r_fault;
    logic           w_fault_nxt;
    logic           w_pause_end;
    logic           w_pre_wrap;
    logic           w_tmo_hit;
    logic           w_loops_met;

    assign w_pre_wrap  = (r_pre == PW'(DIV - 1));
    assign w_pause_end = w_pre_wrap && (r_tick == TW'(PAUSE_TICKS - 1));
    assign w_tmo_hit   = (r_tmo == OW'(TIMEOUT - 1));
    assign w_loops_met = (LOOPS != 0) && (int'(r_cnt) == LOOPS);

    always_comb begin
        w_state_nxt    = r_state;
        w_pre_nxt      = '0;
        w_tick_nxt     = '0;
        w_tmo_nxt      = '0;
        w_sel_nxt      = r_sel;
        w_cnt_nxt      = r_cnt;
        w_run_done_nxt = 1'b0;
        w_fault_nxt    = r_fault;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FWD;
                    w_cnt_nxt   = '0;
                    w_fault_nxt = 1'b0;
                    w_sel_nxt   = 1'b0;
                end
            end

            // Stop outranks done and timeout; a done in the timeout cycle still counts as on time.
            S_FWD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (fwd_done) begin
                    w_state_nxt = S_PAUSE_F;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + OW'(1);
                end
            end

            S_BWD: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bwd_done) begin
                    w_state_nxt = S_PAUSE_B;
                    w_cnt_nxt   = (r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + OW'(1);
                end
            end

            S_PAUSE_F, S_PAUSE_B: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_pause_end) begin
                    if (r_state == S_PAUSE_F) begin
                        w_state_nxt = S_BWD;
                        w_sel_nxt   = 1'b1;
                    end else if (w_loops_met) begin
                        w_state_nxt    = S_IDLE;
                        w_run_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_FWD;
                        w_sel_nxt   = 1'b0;
                    end
                end else if (w_pre_wrap) begin
                    w_tick_nxt = r_tick + TW'(1);
                end else begin
                    w_pre_nxt  = r_pre + PW'(1);
                    w_tick_nxt = r_tick;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Enables and busy are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pre      <= '0;
            r_tick     <= '0;
            r_tmo      <= '0;
            r_fwd_en   <= 1'b0;
            r_bwd_en   <= 1'b0;
            r_sel      <= 1'b0;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_run_done <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pre      <= w_pre_nxt;
            r_tick     <= w_tick_nxt;
            r_tmo      <= w_tmo_nxt;
            r_fwd_en   <= (w_state_nxt == S_FWD);
            r_bwd_en   <= (w_state_nxt == S_BWD);
            r_sel      <= w_sel_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_cnt      <= w_cnt_nxt;
            r_run_done <= w_run_done_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign fwd_en    = r_fwd_en;
    assign bwd_en    = r_bwd_en;
    assign sel       = r_sel;
    assign busy      = r_busy;
    assign sweep_cnt = r_cnt;
    assign run_done  = r_run_done;
    assign fault     = r_fault;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Bench for led_sweep_ctrl: instance A (LOOPS=2, 6-cycle pauses) and instance B (LOOPS=0, 2-cycle pauses).
module tb_led_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic use_b;
    logic t_start, t_stop, t_fwd_done, t_bwd_done;

    logic a_start, a_stop, a_fwd_done, a_bwd_done;
    logic a_fwd_en, a_bwd_en, a_sel, a_busy, a_run_done, a_fault;
    logic [7:0] a_sweep_cnt;
    logic b_start, b_stop, b_fwd_done, b_bwd_done;
    logic b_fwd_en, b_bwd_en, b_sel, b_busy, b_run_done, b_fault;
    logic [7:0] b_sweep_cnt;

    logic o_fwd_en, o_bwd_en, o_sel, o_busy, o_run_done, o_fault;
    logic [7:0] o_sweep_cnt;

    assign a_start    = use_b ? 1'b0 : t_start;
    assign a_stop     = use_b ? 1'b0 : t_stop;
    assign a_fwd_done = use_b ? 1'b0 : t_fwd_done;
    assign a_bwd_done = use_b ? 1'b0 : t_bwd_done;
    assign b_start    = use_b ? t_start    : 1'b0;
    assign b_stop     = use_b ? t_stop     : 1'b0;
    assign b_fwd_done = use_b ? t_fwd_done : 1'b0;
    assign b_bwd_done = use_b ? t_bwd_done : 1'b0;

    assign o_fwd_en    = use_b ? b_fwd_en    : a_fwd_en;
    assign o_bwd_en    = use_b ? b_bwd_en    : a_bwd_en;
    assign o_sel       = use_b ? b_sel       : a_sel;
    assign o_busy      = use_b ? b_busy      : a_busy;
    assign o_run_done  = use_b ? b_run_done  : a_run_done;
    assign o_fault     = use_b ? b_fault     : a_fault;
    assign o_sweep_cnt = use_b ? b_sweep_cnt : a_sweep_cnt;

    led_sweep_ctrl #(.DIV(2), .PAUSE_TICKS(3), .LOOPS(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .stop(a_stop),
        .fwd_done(a_fwd_done), .bwd_done(a_bwd_done),
        .fwd_en(a_fwd_en), .bwd_en(a_bwd_en), .sel(a_sel), .busy(a_busy),
        .sweep_cnt(a_sweep_cnt), .run_done(a_run_done), .fault(a_fault)
    );

    led_sweep_ctrl #(.DIV(1), .PAUSE_TICKS(2), .LOOPS(0), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .stop(b_stop),
        .fwd_done(b_fwd_done), .bwd_done(b_bwd_done),
        .fwd_en(b_fwd_en), .bwd_en(b_bwd_en), .sel(b_sel), .busy(b_busy),
        .sweep_cnt(b_sweep_cnt), .run_done(b_run_done), .fault(b_fault)
    );

    int vecs  = 0;
    int fails = 0;
    int m_cnt;     // reference: completed sweeps in the current run
    int m_loops;   // reference: LOOPS of the selected instance
    int m_pause;   // reference: PAUSE_TICKS*DIV of the selected instance
    bit fin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled at the falling edge; inputs set afterwards reach the next rising edge.
    task automatic tick();
        @(negedge clk);
        chk("overlap_a", {31'd0, a_fwd_en & a_bwd_en}, 0);
        chk("overlap_b", {31'd0, b_fwd_en & b_bwd_en}, 0);
    endtask

    task automatic noise_f();
        t_start    = 1'($urandom);
        t_bwd_done = 1'($urandom);
    endtask

    task automatic noise_b();
        t_start    = 1'($urandom);
        t_fwd_done = 1'($urandom);
    endtask

    task automatic do_start();
        t_fwd_done = 1'b0;
        t_bwd_done = 1'b0;
        t_stop     = 1'b0;
        t_start    = 1'b1;
        m_cnt      = 0;
        tick();
        t_start = 1'b0;
        chk("start_fwd_en", o_fwd_en, 1);
        chk("start_bwd_en", o_bwd_en, 0);
        chk("start_sel", o_sel, 0);
        chk("start_busy", o_busy, 1);
        chk("start_cnt", o_sweep_cnt, 0);
        chk("start_fault", o_fault, 0);
    endtask

    // FWD lasts d cycles: done is sampled on the d-th edge after entry.
    task automatic phase_fwd(input int d);
        for (int i = 1; i < d; i++) begin
            t_fwd_done = 1'b0;
            noise_f();
            tick();
            chk("fwd_hold", o_fwd_en, 1);
            chk("fwd_sel", o_sel, 0);
            chk("fwd_fault", o_fault, 0);
        end
        t_fwd_done = 1'b1;
        noise_f();
        tick();
        t_fwd_done = 1'b0;
        chk("fwd_exit_en", o_fwd_en, 0);
        chk("fwd_exit_bwd", o_bwd_en, 0);
        chk("fwd_exit_busy", o_busy, 1);
    endtask

    task automatic pause_to_bwd();
        for (int i = 1; i < m_pause; i++) begin
            noise_f();
            tick();
            chk("pf_bwd_en", o_bwd_en, 0);
            chk("pf_fwd_en", o_fwd_en, 0);
        end
        noise_f();
        tick();
        t_bwd_done = 1'b0;
        chk("bwd_entry_en", o_bwd_en, 1);
        chk("bwd_entry_sel", o_sel, 1);
    endtask

    task automatic phase_bwd(input int d);
        for (int i = 1; i < d; i++) begin
            t_bwd_done = 1'b0;
            noise_b();
            tick();
            chk("bwd_hold", o_bwd_en, 1);
            chk("bwd_cnt_hold", o_sweep_cnt, m_cnt);
        end
        t_bwd_done = 1'b1;
        noise_b();
        tick();
        t_bwd_done = 1'b0;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        chk("bwd_exit_en", o_bwd_en, 0);
        chk("bwd_exit_cnt", o_sweep_cnt, m_cnt);
    endtask

    task automatic pause_end(output bit done);
        for (int i = 1; i < m_pause; i++) begin
            noise_b();
            tick();
            chk("pb_fwd_en", o_fwd_en, 0);
            chk("pb_run_done", o_run_done, 0);
        end
        noise_b();
        tick();
        t_fwd_done = 1'b0;
        done = (m_loops != 0) && (m_cnt == m_loops);
        if (done) begin
            t_start = 1'b0;
            chk("end_run_done", o_run_done, 1);
            chk("end_busy", o_busy, 0);
            chk("end_fwd_en", o_fwd_en, 0);
            tick();
            chk("end_pulse_once", o_run_done, 0);
            chk("end_idle", o_busy, 0);
        end else begin
            chk("loop_fwd_en", o_fwd_en, 1);
            chk("loop_sel", o_sel, 0);
            chk("loop_run_done", o_run_done, 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; use_b = 1'b0;
        t_start = 1'b0; t_stop = 1'b0; t_fwd_done = 1'b0; t_bwd_done = 1'b0;
        m_loops = 2; m_pause = 6; m_cnt = 0;
        tick(); tick();
        chk("rst_busy", o_busy, 0);
        chk("rst_fwd_en", o_fwd_en, 0);
        chk("rst_bwd_en", o_bwd_en, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_cnt", o_sweep_cnt, 0);
        chk("rst_run_done", o_run_done, 0);
        chk("rst_fault", o_fault, 0);
        rst_n = 1'b1;
        tick();

        // Normal run, done returned 4 cycles after each enable.
        do_start();
        fin = 1'b0;
        while (!fin) begin
            phase_fwd(4); pause_to_bwd(); phase_bwd(4); pause_end(fin);
        end
        chk("normal_cnt", o_sweep_cnt, 2);

        // Random done latencies.
        repeat (3) begin
            do_start();
            fin = 1'b0;
            while (!fin) begin
                phase_fwd($urandom_range(7, 1)); pause_to_bwd();
                phase_bwd($urandom_range(7, 1)); pause_end(fin);
            end
        end

        // Timeout in FWD: fault exactly 8 cycles after entry.
        do_start();
        for (int i = 1; i < 8; i++) begin
            t_start = 1'($urandom);
            tick();
            chk("tmo_fwd_en", o_fwd_en, 1);
            chk("tmo_fault_early", o_fault, 0);
        end
        tick();
        t_start = 1'b0;
        chk("tmo_fault", o_fault, 1);
        chk("tmo_fwd_en_low", o_fwd_en, 0);
        chk("tmo_bwd_en_low", o_bwd_en, 0);
        chk("tmo_idle", o_busy, 0);
        tick();
        chk("tmo_sticky", o_fault, 1);
        do_start();   // start clears the fault

        // Stop in PAUSE_F after one full sweep.
        phase_fwd(3); pause_to_bwd(); phase_bwd(2); pause_end(fin);
        phase_fwd($urandom_range(7, 1));
        repeat (2) begin
            noise_f(); tick();
            chk("pf_wait_bwd_en", o_bwd_en, 0);
        end
        t_stop = 1'b1;
        tick();
        t_stop = 1'b0; t_start = 1'b0; t_bwd_done = 1'b0;
        chk("stop_pf_busy", o_busy, 0);
        chk("stop_pf_en", {30'd0, o_fwd_en, o_bwd_en}, 0);
        chk("stop_pf_cnt", o_sweep_cnt, 1);
        chk("stop_pf_run_done", o_run_done, 0);
        tick();
        chk("stop_pf_no_pulse", o_run_done, 0);
        chk("stop_pf_stays_idle", o_busy, 0);

        // Stop and bwd_done together: stop wins.
        do_start();
        phase_fwd(2); pause_to_bwd();
        t_bwd_done = 1'b0; tick();
        chk("sb_bwd_en", o_bwd_en, 1);
        t_stop = 1'b1; t_bwd_done = 1'b1;
        tick();
        t_stop = 1'b0; t_bwd_done = 1'b0; t_start = 1'b0;
        chk("sb_busy", o_busy, 0);
        chk("sb_bwd_en_low", o_bwd_en, 0);
        chk("sb_cnt", o_sweep_cnt, 0);
        chk("sb_run_done", o_run_done, 0);

        // Reset mid-BWD, after one completed sweep.
        do_start();
        phase_fwd(5); pause_to_bwd(); phase_bwd(5); pause_end(fin);
        phase_fwd(1); pause_to_bwd();
        t_bwd_done = 1'b0; t_start = 1'b0; tick();
        chk("rb_pre_cnt", o_sweep_cnt, 1);
        #2 rst_n = 1'b0; t_start = 1'b1;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_en", {30'd0, o_fwd_en, o_bwd_en}, 0);
        chk("arst_sel", o_sel, 0);
        chk("arst_cnt", o_sweep_cnt, 0);
        chk("arst_flags", {30'd0, o_run_done, o_fault}, 0);
        tick();
        chk("arst_start_ignored", o_busy, 0);
        rst_n = 1'b1; t_start = 1'b0;
        tick(); tick();
        chk("arst_no_restart", o_busy, 0);
        do_start();
        t_stop = 1'b1; tick(); t_stop = 1'b0;
        chk("fresh_stop_idle", o_busy, 0);

        // LOOPS=0 instance: 300 sweeps, saturation at 255, no run_done.
        use_b = 1'b0;
        t_start = 1'b0;
        use_b = 1'b1; m_loops = 0; m_pause = 2;
        tick();
        do_start();
        for (int s = 0; s < 300; s++) begin
            phase_fwd($urandom_range(7, 1)); pause_to_bwd();
            phase_bwd($urandom_range(7, 1)); pause_end(fin);
            chk("sat_no_finish", {31'd0, fin}, 0);
        end
        chk("sat_cnt", o_sweep_cnt, 255);
        t_stop = 1'b1; t_start = 1'b0; tick(); t_stop = 1'b0;
        chk("sat_stop_idle", o_busy, 0);
        chk("sat_cnt_held", o_sweep_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
